sap1_ram: RTL and testbench

- 16x8 program/data RAM for the SAP-1 datapath. It is the responder on the address side: it consumes the 4-bit address from the memory address register and drives the addressed byte onto the W bus when ce_n is low.
- It also contains a programming loader FSM. The loader fills memory sequentially from a byte-stream handshake (valid/ready) before the CPU runs, so no manual address/data switches are needed.

---
 rtl/sap1_ram.sv | 126 ++++++++++++
 tb/tb_sap1_ram.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sap1_ram.sv
// SAP-1 16x8 program/data RAM with a valid/ready byte-stream loader.
// Define SAP1_RAM_INIT_PROGRAM_EN to make clr load the built-in demo program.
module sap1_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] ram_addres,
    input  logic                  ce_n,
    output logic [DATA_WIDTH-1:0] w_bus_out,
    output logic                  w_bus_oe,
    input  logic                  prog_mode,
    input  logic                  prog_valid,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_ready,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic                  prog_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   prog_addr_q;
    logic                    prog_ready_q;
    logic                    prog_done_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    wr_en;

    function automatic logic [DATA_WIDTH-1:0] reset_word(input int idx);
`ifdef SAP1_RAM_INIT_PROGRAM_EN
        // LDA 9; ADD A; ADD B; SUB C; OUT; HLT -> result 0x1C
        case (idx)
            0:       return DATA_WIDTH'(8'h09);
            1:       return DATA_WIDTH'(8'h1A);
            2:       return DATA_WIDTH'(8'h1B);
            3:       return DATA_WIDTH'(8'h2C);
            4:       return DATA_WIDTH'(8'hE0);
            5:       return DATA_WIDTH'(8'hF0);
            9:       return DATA_WIDTH'(8'h10);
            10:      return DATA_WIDTH'(8'h14);
            11:      return DATA_WIDTH'(8'h18);
            12:      return DATA_WIDTH'(8'h20);
            default: return '0;
        endcase
`else
        return (idx < 0) ? '1 : '0;
`endif
    endfunction

    assign wr_en = (state_q == LOAD) && prog_valid;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= reset_word(i);
            end
        end else if (wr_en) begin
            mem_q[prog_addr_q] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            prog_addr_q  <= '0;
            prog_ready_q <= 1'b0;
            prog_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    prog_addr_q <= '0;
                    prog_done_q <= 1'b0;
                    if (prog_mode) begin
                        state_q      <= LOAD;
                        prog_ready_q <= 1'b1;
                    end else begin
                        prog_ready_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!prog_mode) begin
                        state_q      <= IDLE;
                        prog_addr_q  <= '0;
                        prog_ready_q <= 1'b0;
                        prog_done_q  <= 1'b0;
                    end else if (prog_valid) begin
                        prog_addr_q <= prog_addr_q + 1'b1;
                        if (prog_addr_q == ADDR_LAST) begin
                            state_q      <= DONE;
                            prog_ready_q <= 1'b0;
                            prog_done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!prog_mode) begin
                        state_q     <= IDLE;
                        prog_addr_q <= '0;
                        prog_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    prog_addr_q  <= '0;
                    prog_ready_q <= 1'b0;
                    prog_done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Loader has priority: reads are suppressed while programming.
    assign w_bus_oe   = ~ce_n & ~prog_mode & ~clr;
    assign w_bus_out  = w_bus_oe ? mem_q[ram_addres] : '0;
    assign prog_ready = prog_ready_q;
    assign prog_addr  = prog_addr_q;
    assign prog_done  = prog_done_q;

endmodule

// File: tb/tb_sap1_ram.sv
// Directed bench for sap1_ram: read path, loader streaming, stalls,
// overflow drop, simultaneous exit and asynchronous reset mid-load.
module tb_sap1_ram;
    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] ram_addres;
    logic       ce_n;
    logic [7:0] w_bus_out;
    logic       w_bus_oe;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic [3:0] prog_addr;
    logic       prog_done;

    int total = 0;
    int bad = 0;

    sap1_ram dut (
        .clk        (clk),
        .clr        (clr),
        .ram_addres (ram_addres),
        .ce_n       (ce_n),
        .w_bus_out  (w_bus_out),
        .w_bus_oe   (w_bus_oe),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_done  (prog_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_word(input int idx);
`ifdef SAP1_RAM_INIT_PROGRAM_EN
        logic [7:0] tbl [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0,
                                 8'h00, 8'h00, 8'h00, 8'h10, 8'h14, 8'h18,
                                 8'h20, 8'h00, 8'h00, 8'h00};
        return tbl[idx];
`else
        return (idx < 0) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        ram_addres = a;
        ce_n = 1'b0;
        #1;
        chk($sformatf("rd_oe[%0d]", a), 32'(w_bus_oe), 32'd1);
        chk($sformatf("rd_data[%0d]", a), 32'(w_bus_out), 32'(exp));
    endtask

    initial begin
        clr = 1'b1;
        ram_addres = '0;
        ce_n = 1'b1;
        prog_mode = 1'b0;
        prog_valid = 1'b0;
        prog_data = '0;
        #3;
        chk("rst_oe", 32'(w_bus_oe), 32'd0);
        chk("rst_out", 32'(w_bus_out), 32'd0);
        chk("rst_ready", 32'(prog_ready), 32'd0);
        chk("rst_done", 32'(prog_done), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        step();
        clr = 1'b0;
        step();

        // Run mode sweep of reset contents
        for (int i = 0; i < 16; i++) rd(4'(i), init_word(i));

        // Read suppressed while programming
        ram_addres = 4'd3;
        ce_n = 1'b0;
        prog_mode = 1'b1;
        #1;
        chk("prog_rd_oe", 32'(w_bus_oe), 32'd0);
        chk("prog_rd_out", 32'(w_bus_out), 32'd0);
        chk("entry_ready", 32'(prog_ready), 32'd0);
        ce_n = 1'b1;
        step();
        chk("load_ready", 32'(prog_ready), 32'd1);

        // Stream 16 bytes with valid held high
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1;
            prog_data = 8'hA0 + 8'(i);
            chk($sformatf("stream_addr[%0d]", i), 32'(prog_addr), 32'(i));
            chk($sformatf("stream_rdy[%0d]", i), 32'(prog_ready), 32'd1);
            step();
        end
        chk("full_done", 32'(prog_done), 32'd1);
        chk("full_ready", 32'(prog_ready), 32'd0);
        chk("full_addr", 32'(prog_addr), 32'd0);

        // Extra bytes after DONE are dropped
        prog_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ovf_done[%0d]", i), 32'(prog_done), 32'd1);
        end
        prog_valid = 1'b0;
        prog_mode = 1'b0;
        step();
        chk("exit_done", 32'(prog_done), 32'd0);
        chk("exit_addr", 32'(prog_addr), 32'd0);
        rd(4'd5, 8'hA5);
        rd(4'd0, 8'hA0);
        rd(4'd15, 8'hAF);
        ce_n = 1'b1;
        #1;
        chk("ce_off_oe", 32'(w_bus_oe), 32'd0);
        chk("ce_off_out", 32'(w_bus_out), 32'd0);

        // Stall pattern 1,0,0,1
        prog_mode = 1'b1;
        step();
        prog_valid = 1'b1; prog_data = 8'h11; step();
        prog_valid = 1'b0; prog_data = 8'h22; step();
        prog_valid = 1'b0; prog_data = 8'h33; step();
        chk("stall_addr1", 32'(prog_addr), 32'd1);
        prog_valid = 1'b1; prog_data = 8'h44; step();
        prog_valid = 1'b0;
        chk("stall_addr2", 32'(prog_addr), 32'd2);
        prog_mode = 1'b0;
        step();
        rd(4'd0, 8'h11);
        rd(4'd1, 8'h44);
        rd(4'd2, 8'hA2);

        // Async reset after 7 bytes loaded
        prog_mode = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            prog_valid = 1'b1;
            prog_data = 8'h50 + 8'(i);
            step();
        end
        chk("pre_rst_addr", 32'(prog_addr), 32'd7);
        #3;
        clr = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(prog_ready), 32'd0);
        chk("mid_rst_addr", 32'(prog_addr), 32'd0);
        chk("mid_rst_oe", 32'(w_bus_oe), 32'd0);
        prog_valid = 1'b0;
        prog_mode = 1'b0;
        step();
        clr = 1'b0;
        step();
        for (int i = 0; i < 16; i++) rd(4'(i), init_word(i));

        // Restart at 0, then exit on the same edge as a valid byte
        ce_n = 1'b1;
        prog_mode = 1'b1;
        step();
        chk("restart_ready", 32'(prog_ready), 32'd1);
        chk("restart_addr", 32'(prog_addr), 32'd0);
        prog_valid = 1'b1; prog_data = 8'h77; step();
        chk("restart_addr1", 32'(prog_addr), 32'd1);
        prog_mode = 1'b0; prog_data = 8'h88; step();
        prog_valid = 1'b0;
        chk("simul_ready", 32'(prog_ready), 32'd0);
        chk("simul_addr", 32'(prog_addr), 32'd0);
        rd(4'd0, 8'h77);
        rd(4'd1, 8'h88);
        rd(4'd2, init_word(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
